// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity accumulator.
package serial_parity_pkg;

  typedef enum logic [0:0] {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  localparam int DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/xor_gate_using_mux.sv
// Two-input XOR built from a 2:1 mux: b selects between a and ~a.
module xor_gate_using_mux (
  input  logic a,
  input  logic b,
  output logic y
);

  // b = 0 passes a through, b = 1 passes its complement
  always_comb begin
    y = b ? ~a : a;
  end

endmodule

// File: rtl/serial_parity_accumulator.sv
// Bit-serial even-parity accumulator with valid/ready on both sides.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing received-parity
// bit per frame and the out_err output).
module serial_parity_accumulator
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
`ifdef PARITY_CHECK_EN
  output logic out_err,
`endif
  output logic out_parity
);

  // The terminal count is the index of the last bit of a frame; with the
  // check feature the frame carries one extra trailing parity bit.
`ifdef PARITY_CHECK_EN
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int TERM  = FRAME_LEN;
`else
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int TERM  = FRAME_LEN - 1;
`endif
  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             acc_q,   acc_d;
  logic             par_q,   par_d;
  logic             vld_q,   vld_d;
`ifdef PARITY_CHECK_EN
  logic             err_q,   err_d;
`endif

  logic acc_fold;
  logic accept;
  logic last_bit;

  // Single combining element for the running fold.
  xor_gate_using_mux u_fold (
    .a (acc_q),
    .b (in_bit),
    .y (acc_fold)
  );

  // Ready depends on state only so there is no out_ready -> in_ready path.
  always_comb begin
    in_ready = (state_q == S_ACCUM);
    accept   = in_valid && in_ready;
    last_bit = (cnt_q == TERM_C);
  end

  // Next-state, counter, accumulator and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    par_d   = par_q;
    vld_d   = vld_q;
`ifdef PARITY_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_ACCUM: begin
        if (accept) begin
          if (last_bit) begin
`ifdef PARITY_CHECK_EN
            // Trailing bit is the received parity, compared not folded.
            par_d = acc_q;
            err_d = acc_fold;
`else
            par_d = acc_fold;
`endif
            vld_d   = 1'b1;
            acc_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            acc_d = acc_fold;
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ACCUM;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      vld_q   <= vld_d;
`ifdef PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Results are held after the handshake until the next frame lands.
  always_comb begin
    out_valid  = vld_q;
    out_parity = par_q;
`ifdef PARITY_CHECK_EN
    out_err    = err_q;
`endif
  end

endmodule

// File: tb/tb_serial_parity_accumulator.sv
// Directed bench for serial_parity_accumulator (FRAME_LEN = 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_parity_accumulator;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_bit, out_valid, out_ready, out_parity;
`ifdef PARITY_CHECK_EN
  logic out_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_parity_accumulator #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef PARITY_CHECK_EN
    .out_err    (out_err),
`endif
    .out_parity (out_parity)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present nb bits LSB-first; gapped adds (i%4) idle cycles before bit i.
  // Returns on the falling edge after the last bit was accepted.
  task automatic send_frame(input logic [8:0] data, input int nb, input bit gapped);
    for (int i = 0; i < nb; i++) begin
      if (gapped) begin
        for (int g = 0; g < (i % 4); g++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      chk("rdy_bit", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_bit   = data[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [15:0] b2b;
  int idx, nvld, t0, t1;
  logic p0, p1;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_par", {31'd0, out_parity}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
`ifdef PARITY_CHECK_EN
    chk("rst_err", {31'd0, out_err}, 32'd0);
`endif
    rst_n = 1'b1;

`ifdef PARITY_CHECK_EN
    // data 0x03 + trailing 0: parity 0, matches
    send_frame({1'b0, 8'h03}, 9, 1'b0);
    chk("c1_vld", {31'd0, out_valid}, 32'd1);
    chk("c1_par", {31'd0, out_parity}, 32'd0);
    chk("c1_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    chk("c1_clr", {31'd0, out_valid}, 32'd0);
    // data 0x07 + trailing 0: parity 1, mismatch
    send_frame({1'b0, 8'h07}, 9, 1'b0);
    chk("c2_vld", {31'd0, out_valid}, 32'd1);
    chk("c2_par", {31'd0, out_parity}, 32'd1);
    chk("c2_err", {31'd0, out_err}, 32'd1);
    @(negedge clk);
    // data 0x07 + trailing 1: parity 1, matches
    send_frame({1'b1, 8'h07}, 9, 1'b1);
    chk("c3_par", {31'd0, out_parity}, 32'd1);
    chk("c3_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    chk("c3_hold_err", {31'd0, out_err}, 32'd0);
`else
    // Frame 1,0,1,1,0,0,0,0 -> parity 1, single-cycle valid
    send_frame({1'b0, 8'h0D}, 8, 1'b0);
    chk("f1_vld", {31'd0, out_valid}, 32'd1);
    chk("f1_par", {31'd0, out_parity}, 32'd1);
    chk("f1_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("f1_clr", {31'd0, out_valid}, 32'd0);
    chk("f1_rdy2", {31'd0, in_ready}, 32'd1);
    chk("f1_parhold", {31'd0, out_parity}, 32'd1);

    // Frame 1,1,0,0,1,1,0,0 with consumer stalled for 5 cycles
    out_ready = 1'b0;
    send_frame({1'b0, 8'h33}, 8, 1'b0);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("f2_vld", {31'd0, out_valid}, 32'd1);
      chk("f2_par", {31'd0, out_parity}, 32'd0);
      chk("f2_rdy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("f2_clr", {31'd0, out_valid}, 32'd0);
    chk("f2_rdy2", {31'd0, in_ready}, 32'd1);

    // 0xA5 with idle gaps -> parity 0; 0x0D with gaps -> parity 1
    send_frame({1'b0, 8'hA5}, 8, 1'b1);
    chk("f3_vld", {31'd0, out_valid}, 32'd1);
    chk("f3_par", {31'd0, out_parity}, 32'd0);
    @(negedge clk);
    send_frame({1'b0, 8'h0D}, 8, 1'b1);
    chk("f3b_par", {31'd0, out_parity}, 32'd1);
    @(negedge clk);

    // Partial frame of 5 bits discarded by reset, then 0x01 -> parity 1
    send_frame({1'b0, 8'h17}, 5, 1'b0);
    chk("f4_nov", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("f4_rvld", {31'd0, out_valid}, 32'd0);
    chk("f4_rrdy", {31'd0, in_ready}, 32'd1);
    send_frame({1'b0, 8'h01}, 8, 1'b0);
    chk("f4_vld", {31'd0, out_valid}, 32'd1);
    chk("f4_par", {31'd0, out_parity}, 32'd1);
    @(negedge clk);

    // Back-to-back 0xFF then 0x7F, upstream holds bits while not ready
    b2b = 16'h7FFF; idx = 0; nvld = 0; t0 = -1; t1 = -1; p0 = 1'bx; p1 = 1'bx;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (nvld == 0) begin t0 = c; p0 = out_parity; end
        else           begin t1 = c; p1 = out_parity; end
        nvld++;
      end
      if (idx < 16) begin
        in_valid = 1'b1;
        in_bit   = b2b[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("f5_nres", nvld, 32'd2);
    chk("f5_t0", t0, 32'd8);
    chk("f5_period", t1 - t0, 32'd9);
    chk("f5_p0", {31'd0, p0}, 32'd0);
    chk("f5_p1", {31'd0, p1}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_parity_accumulator.md
Name: serial_parity_accumulator

Overview:
- Bit-serial stage that consumes a stream of single bits and folds each accepted bit into a running XOR.
- Emits one parity result per frame of FRAME_LEN bits through a valid/ready output handshake.
- Sits directly downstream of the mux-built XOR primitive and uses it as its per-bit combining element.
- Feeds frame-level checkers and framers that need even parity of fixed-length serial words.

Parameters:
- FRAME_LEN, 8, number of data bits per frame; legal range 2..256.
- CNT_W, $clog2(FRAME_LEN), localparam; bit-counter width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- in_bit  input  1  serial data bit.
- out_valid  output  1  out_parity holds a completed frame result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_parity  output  1  even parity (XOR of all frame bits).
- out_err  output  1  present only with PARITY_CHECK_EN; received parity mismatch.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State becomes S_ACCUM; bit count, accumulator, out_valid, out_parity and out_err all 0.
  - Reset applies mid-frame and mid-hold; a partial frame is discarded and never emitted.
- Input handshake: a bit is accepted at a clk edge where in_valid && in_ready.
  - in_ready = (state == S_ACCUM), combinational from state only, with no path from out_ready.
- S_ACCUM, on each accepted bit:
  - acc <= acc XOR in_bit, with the XOR computed through one xor_gate_using_mux instance.
  - cnt <= cnt + 1.
- On an accepted bit with cnt == FRAME_LEN-1 (the last bit of the frame):
  - out_parity <= acc XOR in_bit; out_valid <= 1.
  - acc <= 0; cnt <= 0; go to S_HOLD.
  - Latency: out_valid rises on the clk edge that accepts the last bit, so it is visible the cycle after the last bit is presented.
- S_HOLD:
  - in_ready = 0; out_valid = 1; out_parity is stable.
  - On out_ready: out_valid <= 0 and go to S_ACCUM.
  - Minimum hold is 1 cycle, so with out_ready tied high the throughput is FRAME_LEN bits per FRAME_LEN+1 cycles.
- in_valid low in S_ACCUM leaves state unchanged; gaps between bits are allowed anywhere in a frame.
- in_valid high while in S_HOLD: the bit is not accepted, and the upstream stage must hold it.
- out_parity is held after the handshake until the next frame overwrites it; consumers sample only while out_valid is high.
- The counter never exceeds FRAME_LEN-1, so there is no wrap-around beyond that point.

Optional Feature:
- Macro PARITY_CHECK_EN.
- When defined:
  - A frame is FRAME_LEN data bits plus 1 trailing received-parity bit, so the counter terminal value is FRAME_LEN.
  - The data bits accumulate as above; the trailing bit is not XORed in.
  - On acceptance of the trailing bit: out_parity <= acc, and out_err <= acc XOR trailing bit.
  - out_err resets to 0, follows the same hold rules as out_parity, and the port exists.
- When not defined: the out_err port is absent and the frame is FRAME_LEN bits.
- CNT_W becomes $clog2(FRAME_LEN+1) when the macro is defined.

Decomposition:
- Package serial_parity_pkg holds:
  - typedef enum logic [0:0] {S_ACCUM, S_HOLD} state_t.
  - Constant DEFAULT_FRAME_LEN = 8.
- One sub-module: the existing xor_gate_using_mux, instantiated once for the acc/in_bit fold.
- The FSM, counter and output registers live in the top module.

Test Plan:
- Reset then frame 1,0,1,1,0,0,0,0 with out_ready=1 -> out_valid high for 1 cycle with out_parity=1; in_ready low exactly that cycle.
- Frame 1,1,0,0,1,1,0,0 with out_ready=0 for 5 cycles -> out_valid stays 1, out_parity=0 stable, in_ready=0 and the pending in_bit not consumed; on out_ready=1 it returns to S_ACCUM.
- Frame with random in_valid gaps (0-3 idle cycles between bits, pattern 0xA5 LSB-first) -> out_parity=0, result identical to the gap-free case.
- rst_n low for 1 cycle after 5 bits of a frame, then full frame 0x01 -> no result from the partial frame; next result has out_parity=1.
- Two back-to-back frames 0xFF then 0x7F with out_ready=1 -> parities 0 then 1, 9-cycle period per frame.
- PARITY_CHECK_EN: data 0x03 + trailing 0 -> out_parity=0, out_err=0; data 0x07 + trailing 0 -> out_parity=1, out_err=1.
